// File: rtl/hazard_flush_ctrl.sv
// Decode-stage load-use hazard detector and taken-branch flush controller
// for the 5-stage RV32I pipeline, with saturating stall/kill counters.
module hazard_flush_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_branch_taken,
    input  logic             perf_clr,
    output logic             stall,
    output logic             kill,
    output logic             issue,
    output logic             flushing,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_kill_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } flush_state_t;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_load;
    logic       hazard;

    sb_entry_t    sb_q [LOAD_LAT];
    logic [2:0]   flush_cnt;
    logic [2:0]   flush_cnt_nxt;
    flush_state_t flush_state;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

    assign opcode   = id_instr[6:0];
    assign rd       = id_instr[11:7];
    assign rs1      = id_instr[19:15];
    assign rs2      = id_instr[24:20];
    assign uses_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign is_load  = (opcode == OP_LOAD);

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (sb_q[k].v && ((uses_rs1 && (rs1 == sb_q[k].rd)) ||
                              (uses_rs2 && (rs2 == sb_q[k].rd)))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && id_valid;
    end

    assign kill     = ex_branch_taken || (flush_cnt != 3'd0);
    assign stall    = hazard && !kill;
    assign issue    = id_valid && !stall && !kill;
    assign flushing = (flush_state == FLUSH);

    // NOTE: the scoreboard is state, not storage: a stale valid bit would stall a fresh instruction after reset, so every entry is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LOAD_LAT; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            // x0 is never recorded, so a load to x0 can never create a hazard.
            sb_q[0] <= '{v: issue && is_load && (rd != 5'd0), rd: rd};
            for (int k = 1; k < LOAD_LAT; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= 3'd0;
        end else begin
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        flush_state   = (flush_cnt != 3'd0) ? FLUSH : IDLE;
        flush_cnt_nxt = flush_cnt;
        case (flush_state)
            IDLE: begin
                if (ex_branch_taken) flush_cnt_nxt = FLUSH_RELOAD;
            end
            FLUSH: begin
                // A taken branch mid-flush restarts the window from the new branch.
                if (ex_branch_taken) flush_cnt_nxt = FLUSH_RELOAD;
                else                 flush_cnt_nxt = flush_cnt - 3'd1;
            end
            default: flush_cnt_nxt = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_kill_cnt  <= '0;
        end else if (perf_clr) begin
            perf_stall_cnt <= '0;
            perf_kill_cnt  <= '0;
        end else begin
            if (stall && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
            if (kill && id_valid && (perf_kill_cnt != '1)) begin
                perf_kill_cnt <= perf_kill_cnt + CNT_W'(1);
            end
        end
    end

endmodule
